// File: rtl/lis3dh_i2c_stub.sv
// LIS3DH accelerometer I2C target model: address match, sub-address pointer, small register subset.
// Optional LIS3DH_I2C_FILTER_EN adds a 3-sample majority filter after the SCL/SDA synchronizers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus free or transfer not addressed to us
// ADDR     | shifting in the 7-bit address + R/W bit
// ADDR_ACK | acknowledging our address
// SUB      | shifting in the sub-address (bit7 = auto-increment)
// SUB_ACK  | acknowledging the sub-address
// WR       | shifting in a data byte to write
// WR_ACK   | acknowledging a written data byte
// RD       | driving a data byte to the master
// RD_ACK   | sampling the master's ACK/NACK

module lis3dh_i2c_stub #(
   parameter logic       SA0      = 1'b0,
   parameter logic [7:0] WHO_AM_I = 8'h33
) (
   input  logic        XCLK,
   input  logic        XRES,
   input  logic        scl,
   input  logic        sda_i,
   output logic        sda_oe,
   input  logic [15:0] out_x,
   output logic [7:0]  ctrl1,
   output logic        wr_stb
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      ADDR     = 4'd1,
      ADDR_ACK = 4'd2,
      SUB      = 4'd3,
      SUB_ACK  = 4'd4,
      WR       = 4'd5,
      WR_ACK   = 4'd6,
      RD       = 4'd7,
      RD_ACK   = 4'd8
   } state_t;

   state_t      state;
   logic [1:0]  scl_sync;
   logic [1:0]  sda_sync;
   logic        scl_f;
   logic        sda_f;
   logic        scl_q;
   logic        sda_q;
   logic [3:0]  cnt;
   logic [6:0]  sh;
   logic [7:0]  tx;
   logic [6:0]  ptr;
   logic        ainc;
   logic        rw;
   logic        ack_phase;
   logic [7:0]  shadow;
   logic [7:0]  rd_data;
   logic [7:0]  byte_in;
   logic        addr_ok;
   logic        scl_rise;
   logic        scl_fall;
   logic        start_c;
   logic        stop_c;

   // Synchronizers reset to the idle-bus level so reset release never looks like a START.
   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

`ifdef LIS3DH_I2C_FILTER_EN
   logic [1:0] scl_hist;
   logic [1:0] sda_hist;

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         scl_hist <= 2'b11;
         sda_hist <= 2'b11;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[0], scl_sync[1]};
         sda_hist <= {sda_hist[0], sda_sync[1]};
         scl_f    <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
         sda_f    <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
      end
   end
`else
   assign scl_f = scl_sync[1];
   assign sda_f = sda_sync[1];
`endif

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise = scl_f & ~scl_q;
   assign scl_fall = ~scl_f & scl_q;
   assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
   assign byte_in  = {sh, sda_f};
   assign addr_ok  = (byte_in[7:1] == (7'h18 | {6'd0, SA0}));

   // 0x29 always returns the high byte captured by the last 0x28 read.
   always_comb begin
      rd_data = 8'h00;
      case (ptr)
         7'h0F:   rd_data = WHO_AM_I;
         7'h20:   rd_data = ctrl1;
         7'h28:   rd_data = out_x[7:0];
         7'h29:   rd_data = shadow;
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         sh        <= 7'd0;
         tx        <= 8'd0;
         ptr       <= 7'd0;
         ainc      <= 1'b0;
         rw        <= 1'b0;
         ack_phase <= 1'b0;
         shadow    <= 8'd0;
         sda_oe    <= 1'b0;
         ctrl1     <= 8'h07;
         wr_stb    <= 1'b0;
      end else begin
         wr_stb <= 1'b0;
         if (start_c) begin
            state  <= ADDR;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
         end else if (stop_c) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               ADDR: if (scl_rise) begin
                  sh  <= byte_in[6:0];
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt <= 4'd0;
                     if (addr_ok) begin
                        rw        <= byte_in[0];
                        ack_phase <= 1'b0;
                        state     <= ADDR_ACK;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               // First SCL fall drives the ACK, second releases it and moves on.
               ADDR_ACK, SUB_ACK, WR_ACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= 1'b1;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     cnt       <= 4'd0;
                     if (state == ADDR_ACK && rw) begin
                        tx     <= {rd_data[6:0], 1'b0};
                        sda_oe <= ~rd_data[7];
                        if (ptr == 7'h28) shadow <= out_x[15:8];
                        state  <= RD;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (state == ADDR_ACK) ? SUB : WR;
                     end
                  end
               end
               SUB: if (scl_rise) begin
                  sh  <= byte_in[6:0];
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt       <= 4'd0;
                     ainc      <= byte_in[7];
                     ptr       <= byte_in[6:0];
                     ack_phase <= 1'b0;
                     state     <= SUB_ACK;
                  end
               end
               WR: if (scl_rise) begin
                  sh  <= byte_in[6:0];
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     cnt <= 4'd0;
                     if (ptr == 7'h20) ctrl1 <= byte_in;
                     wr_stb <= 1'b1;
                     if (ainc) ptr <= ptr + 7'd1;
                     ack_phase <= 1'b0;
                     state     <= WR_ACK;
                  end
               end
               RD: begin
                  if (scl_rise) cnt <= cnt + 4'd1;
                  if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        sda_oe    <= 1'b0;
                        ack_phase <= 1'b0;
                        state     <= RD_ACK;
                     end else begin
                        sda_oe <= ~tx[7];
                        tx     <= {tx[6:0], 1'b0};
                     end
                  end
               end
               // ack_phase marks an ACK seen; the next byte is loaded on the following fall.
               RD_ACK: begin
                  if (scl_rise) begin
                     if (!sda_f) begin
                        if (ainc) ptr <= ptr + 7'd1;
                        ack_phase <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end else if (scl_fall && ack_phase) begin
                     ack_phase <= 1'b0;
                     cnt       <= 4'd0;
                     tx        <= {rd_data[6:0], 1'b0};
                     sda_oe    <= ~rd_data[7];
                     if (ptr == 7'h28) shadow <= out_x[15:8];
                     state     <= RD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lis3dh_i2c_stub.sv
// Directed bench for lis3dh_i2c_stub: bit-banged I2C master with open-drain SDA model.
module tb_lis3dh_i2c_stub;

   logic        XCLK = 1'b0;
   logic        XRES = 1'b0;
   logic        scl = 1'b1;
   logic        m_sda = 1'b1;
   logic        sda_i;
   logic        sda_oe;
   logic [15:0] out_x = 16'h0000;
   logic [7:0]  ctrl1;
   logic        wr_stb;

   int n_assert = 0;
   int n_fail = 0;
   int wr_cnt = 0;
   logic mon_en = 1'b0;
   logic oe_seen = 1'b0;

   lis3dh_i2c_stub dut (
      .XCLK   (XCLK),
      .XRES   (XRES),
      .scl    (scl),
      .sda_i  (sda_i),
      .sda_oe (sda_oe),
      .out_x  (out_x),
      .ctrl1  (ctrl1),
      .wr_stb (wr_stb)
   );

   assign sda_i = m_sda & ~sda_oe;

   always #5 XCLK = ~XCLK;

   always @(negedge XCLK) begin
      if (wr_stb) wr_cnt++;
      if (mon_en && sda_oe) oe_seen = 1'b1;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge XCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      if (scl == 1'b0) begin
         wait_clk(4); m_sda = 1'b1;
         wait_clk(6); scl = 1'b1;
         wait_clk(10);
      end
      m_sda = 1'b0;
      wait_clk(10); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(4); m_sda = 1'b0;
      wait_clk(6); scl = 1'b1;
      wait_clk(10); m_sda = 1'b1;
      wait_clk(10);
   endtask

   task automatic send_bit(input logic b);
      wait_clk(4); m_sda = b;
      wait_clk(6); scl = 1'b1;
      wait_clk(10); scl = 1'b0;
   endtask

   task automatic get_ack(output logic ack);
      wait_clk(4); m_sda = 1'b1;
      wait_clk(6); scl = 1'b1;
      wait_clk(5); ack = sda_i;
      wait_clk(5); scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      get_ack(ack);
   endtask

   task automatic recv_byte(input logic ack_in, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         wait_clk(4); m_sda = 1'b1;
         wait_clk(6); scl = 1'b1;
         wait_clk(5); d[i] = sda_i;
         wait_clk(5); scl = 1'b0;
      end
      send_bit(ack_in);
   endtask

   task automatic reg_write(input logic [7:0] sub, input logic [7:0] data);
      logic ack;
      i2c_start();
      send_byte(8'h30, ack); chk("wr_addr_ack", 16'(ack), 16'h0);
      send_byte(sub, ack);   chk("wr_sub_ack", 16'(ack), 16'h0);
      send_byte(data, ack);  chk("wr_data_ack", 16'(ack), 16'h0);
      i2c_stop();
   endtask

   task automatic reg_read(input logic [7:0] sub, output logic [7:0] d);
      logic ack;
      i2c_start();
      send_byte(8'h30, ack); chk("rd_addr_w_ack", 16'(ack), 16'h0);
      send_byte(sub, ack);   chk("rd_sub_ack", 16'(ack), 16'h0);
      i2c_start();
      send_byte(8'h31, ack); chk("rd_addr_r_ack", 16'(ack), 16'h0);
      recv_byte(1'b1, d);
      i2c_stop();
   endtask

   initial begin
      logic [7:0] d;
      logic ack;
      int wr_base;

      // reset state
      wait_clk(5);
      chk("rst_sda_oe", 16'(sda_oe), 16'h0);
      chk("rst_ctrl1", 16'(ctrl1), 16'h07);
      chk("rst_wr_stb", 16'(wr_stb), 16'h0);
      chk("rst_state", 16'(dut.state), 16'h0);
      XRES = 1'b1;
      wait_clk(20);

      // WHO_AM_I
      reg_read(8'h0F, d);
      chk("who_am_i", 16'(d), 16'h33);

      // CTRL_REG1 write and readback
      wr_base = wr_cnt;
      reg_write(8'h20, 8'h57);
      chk("ctrl1_write", 16'(ctrl1), 16'h57);
      chk("ctrl1_wr_stb", 16'(wr_cnt - wr_base), 16'd1);
      reg_read(8'h20, d);
      chk("ctrl1_readback", 16'(d), 16'h57);

      // burst read with auto-increment, out_x changed between bytes
      out_x = 16'hA5C3;
      i2c_start();
      send_byte(8'h30, ack); chk("burst_addr_ack", 16'(ack), 16'h0);
      send_byte(8'hA8, ack); chk("burst_sub_ack", 16'(ack), 16'h0);
      i2c_start();
      send_byte(8'h31, ack); chk("burst_raddr_ack", 16'(ack), 16'h0);
      recv_byte(1'b0, d);
      chk("burst_lo", 16'(d), 16'h00C3);
      out_x = 16'h1234;
      recv_byte(1'b1, d);
      chk("burst_hi_shadow", 16'(d), 16'h00A5);
      i2c_stop();

      // fresh single reads re-latch the shadow
      reg_read(8'h28, d);
      chk("single_lo", 16'(d), 16'h34);
      reg_read(8'h29, d);
      chk("single_hi", 16'(d), 16'h12);

      // write to read-only register: ignored, strobe still pulses
      wr_base = wr_cnt;
      reg_write(8'h0F, 8'hAA);
      chk("ro_wr_stb", 16'(wr_cnt - wr_base), 16'd1);
      chk("ro_ctrl1_kept", 16'(ctrl1), 16'h57);
      reg_read(8'h0F, d);
      chk("ro_who_am_i", 16'(d), 16'h33);

      // auto-increment write: 0x1F (ignored) then 0x20
      wr_base = wr_cnt;
      i2c_start();
      send_byte(8'h30, ack); chk("ainc_addr_ack", 16'(ack), 16'h0);
      send_byte(8'h9F, ack); chk("ainc_sub_ack", 16'(ack), 16'h0);
      send_byte(8'h11, ack); chk("ainc_d0_ack", 16'(ack), 16'h0);
      send_byte(8'h22, ack); chk("ainc_d1_ack", 16'(ack), 16'h0);
      i2c_stop();
      chk("ainc_ctrl1", 16'(ctrl1), 16'h22);
      chk("ainc_wr_stb", 16'(wr_cnt - wr_base), 16'd2);

      // address mismatch
      oe_seen = 1'b0;
      mon_en = 1'b1;
      i2c_start();
      send_byte(8'h32, ack); chk("mismatch_nack", 16'(ack), 16'h1);
      chk("mismatch_idle", 16'(dut.state), 16'h0);
      send_byte(8'h0F, ack); chk("mismatch_nack2", 16'(ack), 16'h1);
      i2c_stop();
      mon_en = 1'b0;
      chk("mismatch_no_oe", 16'(oe_seen), 16'h0);

      // abort: reset while driving bit 7 (0) of CTRL_REG1 = 0x22
      i2c_start();
      send_byte(8'h30, ack); chk("abort_addr_ack", 16'(ack), 16'h0);
      send_byte(8'h20, ack); chk("abort_sub_ack", 16'(ack), 16'h0);
      i2c_start();
      send_byte(8'h31, ack); chk("abort_raddr_ack", 16'(ack), 16'h0);
      wait_clk(4); m_sda = 1'b1;
      wait_clk(6); scl = 1'b1;
      wait_clk(3);
      chk("abort_pre_oe", 16'(sda_oe), 16'h1);
      XRES = 1'b0;
      #1;
      chk("abort_oe_released", 16'(sda_oe), 16'h0);
      chk("abort_ctrl1_reset", 16'(ctrl1), 16'h07);
      wait_clk(5);
      XRES = 1'b1;
      wait_clk(20);
      reg_write(8'h20, 8'h3C);
      chk("post_abort_ctrl1", 16'(ctrl1), 16'h3C);
      reg_read(8'h20, d);
      chk("post_abort_read", 16'(d), 16'h3C);

      // 1-cycle SCL glitch during the first data bit of 0x57
      i2c_start();
      send_byte(8'h30, ack); chk("glitch_addr_ack", 16'(ack), 16'h0);
      send_byte(8'h20, ack); chk("glitch_sub_ack", 16'(ack), 16'h0);
      wait_clk(4); m_sda = 1'b0;
      wait_clk(2); scl = 1'b1;
      wait_clk(1); scl = 1'b0;
      wait_clk(3); scl = 1'b1;
      wait_clk(10); scl = 1'b0;
      for (int i = 6; i >= 0; i--) send_bit(1'(8'h57 >> i));
      get_ack(ack);
      i2c_stop();
`ifdef LIS3DH_I2C_FILTER_EN
      chk("glitch_ctrl1", 16'(ctrl1), 16'h57);
      chk("glitch_ack", 16'(ack), 16'h0);
`else
      chk("glitch_ctrl1", 16'(ctrl1), 16'h2B);
      chk("glitch_ack", 16'(ack), 16'h1);
`endif
      reg_read(8'h0F, d);
      chk("glitch_recover", 16'(d), 16'h33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lis3dh_i2c_stub.md
# lis3dh_i2c_stub

Synthesizable I2C target model of the LIS3DH accelerometer. It is the responder end of the bit-banged I2C master that firmware drives through OPORT/IPORT. It lets the MAX1000 I2C build and the simulation bench run sensor firmware without the real part. It decodes START/STOP, matches the 7-bit address, keeps a sub-address pointer with auto-increment, ACKs, and serves a small LIS3DH register subset over open-drain SDA.

## Interface
Parameters:
- SA0, 1'b0: address select pin level; slave address = 7'h18 | SA0.
- WHO_AM_I, 8'h33: value returned at register 0x0F.

Ports:
- XCLK  in  1  system clock. Oversamples SCL/SDA.
- XRES  in  1  reset, asynchronous, active-low.
- scl  in  1  I2C clock from the bus, already resolved from open-drain.
- sda_i  in  1  resolved SDA bus level.
- sda_oe  out  1  1 = pull SDA low. The board wrapper drives 1'bz otherwise.
- out_x  in  16  X-axis sample served at OUT_X_L (0x28) and OUT_X_H (0x29).
- ctrl1  out  8  current CTRL_REG1 (0x20) contents.
- wr_stb  out  1  one-cycle pulse after each data byte is written to any register.

## Operation
- **Synchronizer:** scl and sda_i each go through a 2-flop synchronizer. Edge and condition detection uses the synchronized values only.
- **Bus conditions:**
  - START or repeated START: synced SDA 1→0 while SCL=1.
  - STOP: synced SDA 0→1 while SCL=1.
  - START and STOP win over any state.
- **Sampling and driving:**
  - Bits are sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the SCL falling edge.
- **FSM states:** IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK.
  - IDLE: wait for START. START→ADDR.
  - ADDR: shift 8 bits. On match → ADDR_ACK. On mismatch → IDLE; SDA is never driven.
  - ADDR_ACK, R/W=0: drive ACK, then → SUB.
  - ADDR_ACK, R/W=1: drive ACK, then load the byte at the pointer → RD.
  - SUB: shift 8 bits. Bit7 = auto-increment enable. Bits[6:0] = pointer. → SUB_ACK (ACK) → WR.
  - WR: shift a byte. Write it if the register is writable, pulse wr_stb, → WR_ACK (ACK). If auto-increment is set, the pointer increments. → WR.
  - RD: drive bits (sda_oe = ~bit) for 8 SCL periods → RD_ACK. Sample the master bit on the 9th rising edge.
  - RD_ACK: if ACK=0, advance the pointer (if auto-increment), load the next byte → RD. If NACK, release SDA → IDLE.
  - Repeated START in any state → ADDR. The pointer and auto-increment flag are kept, so a write-pointer/read sequence works.
- **Register map:**
  - 0x0F: WHO_AM_I, read-only.
  - 0x20: CTRL_REG1, R/W, reset 8'h07.
  - 0x28: out_x[7:0], read-only.
  - 0x29: out_x[15:8], read-only.
  - All other addresses read 8'h00. Writes to them are ACKed and ignored, and wr_stb still pulses.
- **Read coherence:** a read of 0x28 latches out_x[15:8] into a shadow register. A following read of 0x29 returns the shadow, not the live value.
- **Pointer:** 7-bit; wraps from 0x7F to 0x00.

## Timing
- **Reset values:**
  - sda_oe=0, ctrl1=8'h07, wr_stb=0.
  - FSM=IDLE; pointer=0; shadow=0.
- **Reset mid-transfer:** SDA is released asynchronously.
- **Detection latency:**
  - SCL/SDA edge to internal detection: 2 XCLK cycles.
  - Plus 2 cycles when the glitch filter (below) is enabled.
- **Output timing:**
  - sda_oe updates on the XCLK cycle after a detected SCL fall.
  - wr_stb asserts on the cycle after the 8th data rising edge is detected.
- **Bus requirements:**
  - SCL high and low phases ≥ 6 XCLK cycles.
  - SDA must change ≥ 3 XCLK cycles after SCL falls. This separates data transitions from START/STOP.

## Configuration
- **LIS3DH_I2C_FILTER_EN defined:** a 3-sample majority filter follows each synchronizer. Pulses of ≤ 1 XCLK are rejected. Latency +2 cycles.
- **Not defined:** raw 2-flop synchronized signals are used directly.

## Test plan
- **WHO_AM_I read:** START, 0x30, 0x0F, repeated START, 0x31, read 1 byte + NACK, STOP.
  - Required: 0x33 returned.
  - Required: ACK on all three address/pointer bytes.
- **CTRL_REG1 write/readback:** write 0x20 ← 0x57.
  - Required: ctrl1=8'h57 and one wr_stb pulse.
  - Required: readback returns 0x57.
- **Burst read with auto-increment:** out_x=16'hA5C3; pointer 0xA8; read 2 bytes (ACK, NACK).
  - Required: C3 then A5.
  - Then change out_x between the bytes: the high byte still returns the shadow value.
- **Address mismatch:** address byte 0x32 with SA0=0.
  - Required: sda_oe stays 0 for the whole transfer, and the FSM returns to IDLE.
- **Abort:** assert XRES low in the middle of a read byte.
  - Required: sda_oe=0 immediately and ctrl1=8'h07.
  - Required: the next full transaction succeeds.
- **Glitch filter (LIS3DH_I2C_FILTER_EN):** 1-cycle SCL glitch during a data bit.
  - Required: with the macro defined, the received byte is unchanged.
  - Required: without the macro, the bit count is corrupted.
